// File: rtl/adder_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_bist_ctrl_if
//  Brief    : Bundle between the adder BIST sequencer and its adder/harness.
//  Revision : 1.0  initial release
// ============================================================================
interface adder_bist_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       fail_count;
  logic [7:0]       first_fail_idx;
  logic             first_fail_valid;

  modport master (
    input  start, dut_sum, dut_cout,
    output op_a, op_b, cin, busy, done, pass,
           fail_count, first_fail_idx, first_fail_valid
  );

  modport slave (
    output start, dut_sum, dut_cout,
    input  op_a, op_b, cin, busy, done, pass,
           fail_count, first_fail_idx, first_fail_valid
  );
endinterface
`default_nettype wire

// File: rtl/adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adder_bist_ctrl
//  Brief    : Deterministic-pattern BIST sequencer and checker for a
//             ripple-carry adder; reports verdict, fail count, first failure.
//  Revision : 1.0  initial release
// ============================================================================
module adder_bist_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  adder_bist_ctrl_if.master   bus
);
  localparam logic [7:0] c_last_idx    = 8'(WIDTH + 3);
  localparam logic [3:0] c_settle_last = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_idx;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_op_a, r_op_b;
  logic             r_cin;
  logic             r_done;
  logic [7:0]       r_fail_count;
  logic [7:0]       r_first_fail_idx;
  logic             r_first_fail_valid;

  logic [2*WIDTH:0] w_pat_first, w_pat_next;
  logic [WIDTH:0]   w_golden;
  logic             w_mismatch;

  // Returns {cin, a, b} for a schedule index.
  function automatic logic [2*WIDTH:0] pattern(input logic [7:0] idx);
    logic [WIDTH-1:0] a, b, alt;
    logic             c;
    for (int i = 0; i < WIDTH; i++) alt[i] = ~i[0];
    a = '0;
    b = '0;
    c = 1'b0;
    case (idx)
      8'd0: c = 1'b0;
      8'd1: begin a = '1; c = 1'b1; end
      8'd2: begin a = '1; b = '1; c = 1'b1; end
      8'd3: begin a = alt; b = ~alt; end
      default: begin
        a = '1;
        b = {{(WIDTH-1){1'b0}}, 1'b1} << (idx - 8'd4);
      end
    endcase
    return {c, a, b};
  endfunction

  assign w_pat_first = pattern(8'd0);
  assign w_pat_next  = pattern(r_idx + 8'd1);
  assign w_golden    = {1'b0, r_op_a} + {1'b0, r_op_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_mismatch  = ({bus.dut_cout, bus.dut_sum} != w_golden);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_APPLY;
      S_APPLY:        w_state_nxt = (SETTLE == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE:       if (r_cnt == c_settle_last) w_state_nxt = S_CHECK;
      S_CHECK:        w_state_nxt = (r_idx == c_last_idx) ? S_DONE : S_APPLY;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_idx              <= '0;
      r_cnt              <= '0;
      r_op_a             <= '0;
      r_op_b             <= '0;
      r_cin              <= 1'b0;
      r_done             <= 1'b0;
      r_fail_count       <= '0;
      r_first_fail_idx   <= '0;
      r_first_fail_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_idx              <= '0;
            r_done             <= 1'b0;
            r_fail_count       <= '0;
            r_first_fail_idx   <= '0;
            r_first_fail_valid <= 1'b0;
            {r_cin, r_op_a, r_op_b} <= w_pat_first;
          end
        end
        S_APPLY:  r_cnt <= '0;
        S_SETTLE: r_cnt <= r_cnt + 4'd1;
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
            if (!r_first_fail_valid) begin
              r_first_fail_idx   <= r_idx;
              r_first_fail_valid <= 1'b1;
            end
          end
          // Operands stay put after the final pattern; only the verdict moves.
          if (r_idx == c_last_idx) begin
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 8'd1;
            {r_cin, r_op_a, r_op_b} <= w_pat_next;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.op_a             = r_op_a;
  assign bus.op_b             = r_op_b;
  assign bus.cin              = r_cin;
  assign bus.busy             = (r_state == S_APPLY) || (r_state == S_SETTLE) ||
                                (r_state == S_CHECK);
  assign bus.done             = r_done;
  assign bus.pass             = r_done && (r_fail_count == 8'd0);
  assign bus.fail_count       = r_fail_count;
  assign bus.first_fail_idx   = r_first_fail_idx;
  assign bus.first_fail_valid = r_first_fail_valid;
endmodule
`default_nettype wire

// File: tb/tb_adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_bist_ctrl
//  Brief    : Directed bench for adder_bist_ctrl with ideal, faulty and
//             pipelined adder models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_bist_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;   // 0 ideal, 1 sum[31] stuck-at-0, 2 cout stuck-at-0
  int   compares = 0;
  int   mismatches = 0;

  always #5 clk = ~clk;

  adder_bist_ctrl_if #(.WIDTH(W)) if0 ();
  adder_bist_ctrl_if #(.WIDTH(W)) if1 ();
  adder_bist_ctrl_if #(.WIDTH(W)) if2 ();

  adder_bist_ctrl #(.WIDTH(W), .SETTLE(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  adder_bist_ctrl #(.WIDTH(W), .SETTLE(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  adder_bist_ctrl #(.WIDTH(W), .SETTLE(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  function automatic logic [W:0] add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Combinational adder with selectable stuck-at faults.
  logic [W:0] full0;
  assign full0        = add(if0.op_a, if0.op_b, if0.cin);
  assign if0.dut_sum  = (mode == 1) ? {1'b0, full0[W-2:0]} : full0[W-1:0];
  assign if0.dut_cout = (mode == 2) ? 1'b0 : full0[W];

  // Two-register-stage adders.
  logic [W:0] p1a, p2a, p1b, p2b;
  always @(posedge clk) begin
    if (rst) begin
      p1a <= '0; p2a <= '0; p1b <= '0; p2b <= '0;
    end else begin
      p1a <= add(if1.op_a, if1.op_b, if1.cin);
      p2a <= p1a;
      p1b <= add(if2.op_a, if2.op_b, if2.cin);
      p2b <= p1b;
    end
  end
  assign if1.dut_sum  = p2a[W-1:0];
  assign if1.dut_cout = p2a[W];
  assign if2.dut_sum  = p2b[W-1:0];
  assign if2.dut_cout = p2b[W];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compares++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W:0] exp_ops(input int p);
    case (p)
      0:       return {1'b0, 32'h0000_0000, 32'h0000_0000};
      1:       return {1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      2:       return {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      3:       return {1'b0, 32'h5555_5555, 32'hAAAA_AAAA};
      default: return {1'b0, 32'hFFFF_FFFF, 32'h0000_0001 << (p - 4)};
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? if0.done : (sel == 1) ? if1.done : if2.done;
  endfunction

  // Cycles from now until done is seen, -1 on timeout.
  task automatic wait_done(input int sel, output int k);
    k = -1;
    for (int i = 0; i < 400; i++) begin
      if (done_of(sel)) begin
        k = i;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) if0.start = 1'b1; else if (sel == 1) if1.start = 1'b1; else if2.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
  endtask

  // Full run on instance 0, checking the operand schedule per pattern.
  task automatic run0(input bit noise, output int done_k);
    done_k = -1;
    pulse_start(0);
    chk("busy_rise", 128'(if0.busy), 128'(1));
    for (int k = 0; k < 400; k++) begin
      if ((k % 4 == 0) && (k / 4 < 36))
        chk($sformatf("ops_idx%0d", k / 4), 128'({if0.cin, if0.op_a, if0.op_b}), 128'(exp_ops(k / 4)));
      if (mode == 2 && k == 16) chk("gold_idx4", 128'(full0), 128'(33'h1_0000_0000));
      if (mode == 2 && k == 140) chk("gold_idx35", 128'(full0), 128'(33'h1_7FFF_FFFF));
      if (if0.done) begin
        done_k = k;
        break;
      end
      if0.start = noise && (k == 5 || k == 37 || k == 90 || k == 143);
      @(posedge clk); #1;
    end
    if0.start = 1'b0;
  endtask

  typedef struct {
    int         mode;
    logic [7:0] fc;
    logic       ffv;
    logic [7:0] ffi;
    logic       pass;
  } vec_t;

  vec_t vecs[3];
  int   dk;

  initial begin
    vecs[0] = '{0, 8'd0,  1'b0, 8'd0, 1'b1};
    vecs[1] = '{1, 8'd2,  1'b1, 8'd2, 1'b0};
    vecs[2] = '{2, 8'd34, 1'b1, 8'd1, 1'b0};
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", 128'({if0.op_a, if0.op_b, if0.cin, if0.busy, if0.done, if0.pass,
        if0.fail_count, if0.first_fail_idx, if0.first_fail_valid}), 128'(0));

    for (int i = 0; i < 3; i++) begin
      mode = vecs[i].mode;
      run0(i == 1, dk);
      chk($sformatf("m%0d_done_cycles", i), 128'(dk), 128'(144));
      chk($sformatf("m%0d_fail_count", i), 128'(if0.fail_count), 128'(vecs[i].fc));
      chk($sformatf("m%0d_ffv", i), 128'(if0.first_fail_valid), 128'(vecs[i].ffv));
      if (vecs[i].ffv) chk($sformatf("m%0d_ffi", i), 128'(if0.first_fail_idx), 128'(vecs[i].ffi));
      chk($sformatf("m%0d_pass", i), 128'(if0.pass), 128'(vecs[i].pass));
      chk($sformatf("m%0d_busy", i), 128'(if0.busy), 128'(0));
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("m%0d_done_hold", i), 128'(if0.done), 128'(1));
    end

    // Restart from DONE after a failing run.
    mode = 0;
    pulse_start(0);
    chk("restart_clear", 128'({if0.fail_count, if0.first_fail_valid, if0.done, if0.pass, if0.busy}),
        128'({8'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
    wait_done(0, dk);
    chk("restart_done_cycles", 128'(dk), 128'(144));
    chk("restart_pass", 128'(if0.pass), 128'(1));

    // Reset during SETTLE of idx 10.
    pulse_start(0);
    repeat (41) @(posedge clk);
    #1;
    chk("idx10_ops", 128'({if0.op_a, if0.op_b, if0.busy}), 128'({32'hFFFF_FFFF, 32'h0000_0040, 1'b1}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_reset", 128'({if0.op_a, if0.op_b, if0.cin, if0.busy, if0.done, if0.pass,
        if0.fail_count, if0.first_fail_idx, if0.first_fail_valid}), 128'(0));
    run0(1'b0, dk);
    chk("post_reset_done_cycles", 128'(dk), 128'(144));
    chk("post_reset_pass", 128'(if0.pass), 128'(1));

    // Pipelined adder, too little settle time.
    pulse_start(1);
    wait_done(1, dk);
    chk("pipe_s0_finished", 128'(dk >= 0), 128'(1));
    chk("pipe_s0_pass", 128'(if1.pass), 128'(0));
    chk("pipe_s0_has_fails", 128'(if1.fail_count != 8'd0), 128'(1));

    // Pipelined adder with one settle cycle.
    pulse_start(2);
    wait_done(2, dk);
    chk("pipe_s1_done_cycles", 128'(dk), 128'(108));
    chk("pipe_s1_pass", 128'(if2.pass), 128'(1));
    chk("pipe_s1_fail_count", 128'(if2.fail_count), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end
endmodule
`default_nettype wire
